// File: rtl/isp_stream_tx.sv
// Frame-source transmitter: reads a raw Bayer frame from a synchronous frame memory in raster
// order and emits the tagged ISP input pixel stream with row/frame end flags and a done pulse.
module isp_stream_tx #(
    parameter int unsigned COLOR_DEPTH   = 8,
    parameter int unsigned COLOR_BIT_CNT = 2,
    parameter int unsigned MODE_BIT_CNT  = 4,
    parameter int unsigned DIM_W         = 11,
    parameter int unsigned ADDR_W        = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DIM_W-1:0]         cfg_cols,
    input  logic [DIM_W-1:0]         cfg_rows,
    input  logic [1:0]               cfg_bayer,
    input  logic [ADDR_W-1:0]        cfg_base,
    input  logic [MODE_BIT_CNT-1:0]  cfg_mode,
    input  logic                     pause,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [COLOR_DEPTH-1:0]   mem_rd_data,
    output logic [COLOR_DEPTH-1:0]   pixel_out,
    output logic                     valid_out,
    output logic [COLOR_BIT_CNT-1:0] color_out,
    output logic                     last_col_out,
    output logic                     last_pic_out,
    output logic [MODE_BIT_CNT-1:0]  mode_out,
    output logic                     busy,
    output logic                     done
);

    localparam logic [COLOR_BIT_CNT-1:0] RED   = COLOR_BIT_CNT'(0);
    localparam logic [COLOR_BIT_CNT-1:0] GREEN = COLOR_BIT_CNT'(1);
    localparam logic [COLOR_BIT_CNT-1:0] BLUE  = COLOR_BIT_CNT'(2);
    localparam logic [COLOR_BIT_CNT-1:0] VOID  = COLOR_BIT_CNT'(3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [DIM_W-1:0]          cols_q, cols_d;
    logic [DIM_W-1:0]          rows_q, rows_d;
    logic [DIM_W-1:0]          col_q, col_d;
    logic [DIM_W-1:0]          row_q, row_d;
    logic [1:0]                bayer_q, bayer_d;
    logic [MODE_BIT_CNT-1:0]   mode_q, mode_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      zero_q, zero_d;

    logic                      tag_vld_q;
    logic [COLOR_BIT_CNT-1:0]  tag_color_q;
    logic                      tag_lc_q;
    logic                      tag_lp_q;

    logic [COLOR_DEPTH-1:0]    pixel_q;
    logic                      valid_q;
    logic [COLOR_BIT_CNT-1:0]  color_q;
    logic                      lc_q;
    logic                      lp_q;

    logic                      issue;
    logic                      last_col;
    logic                      last_row;
    logic                      row_ph;
    logic                      col_ph;
    logic [COLOR_BIT_CNT-1:0]  color_c;

    assign last_col = (col_q == cols_q - DIM_W'(1));
    assign last_row = (row_q == rows_q - DIM_W'(1));

    // Every CFA phase is RGGB with the row and/or column parity flipped.
    assign row_ph = row_q[0] ^ bayer_q[1];
    assign col_ph = col_q[0] ^ bayer_q[0];

    always_comb begin
        color_c = RED;
        if (row_ph != col_ph) begin
            color_c = GREEN;
        end else if (row_ph) begin
            color_c = BLUE;
        end
    end

    always_comb begin
        state_d = state_q;
        cols_d  = cols_q;
        rows_d  = rows_q;
        col_d   = col_q;
        row_d   = row_q;
        bayer_d = bayer_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        zero_d  = zero_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (zero_q) begin
                    zero_d  = 1'b0;
                    state_d = DONE;
                end else if (start) begin
                    cols_d  = cfg_cols;
                    rows_d  = cfg_rows;
                    bayer_d = cfg_bayer;
                    mode_d  = cfg_mode;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = cfg_base;
                    // An empty frame still spends one idle cycle before its done pulse.
                    if (cfg_cols == '0 || cfg_rows == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (!pause) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + DIM_W'(1);
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!tag_vld_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cols_q  <= '0;
            rows_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            bayer_q <= '0;
            mode_q  <= '0;
            addr_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cols_q  <= cols_d;
            rows_q  <= rows_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bayer_q <= bayer_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            zero_q  <= zero_d;
        end
    end

    // Tag stage lines up with the memory's read data cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q   <= 1'b0;
            tag_color_q <= VOID;
            tag_lc_q    <= 1'b0;
            tag_lp_q    <= 1'b0;
        end else begin
            tag_vld_q <= issue;
            if (issue) begin
                tag_color_q <= color_c;
                tag_lc_q    <= last_col;
                tag_lp_q    <= last_col & last_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= '0;
            valid_q <= 1'b0;
            color_q <= VOID;
            lc_q    <= 1'b0;
            lp_q    <= 1'b0;
        end else begin
            valid_q <= tag_vld_q;
            color_q <= tag_vld_q ? tag_color_q : VOID;
            lc_q    <= tag_vld_q & tag_lc_q;
            lp_q    <= tag_vld_q & tag_lp_q;
            if (tag_vld_q) begin
                pixel_q <= mem_rd_data;
            end
        end
    end

    assign mem_rd_en    = issue;
    assign mem_addr     = addr_q;
    assign pixel_out    = pixel_q;
    assign valid_out    = valid_q;
    assign color_out    = color_q;
    assign last_col_out = lc_q;
    assign last_pic_out = lp_q;
    assign mode_out     = mode_q;
    assign busy         = (state_q == STREAM) || (state_q == DRAIN);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_isp_stream_tx.sv
// Directed bench for isp_stream_tx; cycle 0 is the cycle in which start is driven high,
// and every capture index k refers to the DUT outputs sampled mid-cycle k.
module tb_isp_stream_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [10:0] cfg_cols;
    logic [10:0] cfg_rows;
    logic [1:0]  cfg_bayer;
    logic [19:0] cfg_base;
    logic [3:0]  cfg_mode;
    logic        pause;
    logic        mem_rd_en;
    logic [19:0] mem_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  pixel_out;
    logic        valid_out;
    logic [1:0]  color_out;
    logic        last_col_out;
    logic        last_pic_out;
    logic [3:0]  mode_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic        c_rd   [32];
    logic [19:0] c_addr [32];
    logic        c_vld  [32];
    logic [7:0]  c_pix  [32];
    logic [1:0]  c_col  [32];
    logic        c_lc   [32];
    logic        c_lp   [32];
    logic        c_done [32];
    logic        c_busy [32];
    logic [3:0]  c_mode [32];

    isp_stream_tx #(
        .COLOR_DEPTH  (8),
        .COLOR_BIT_CNT(2),
        .MODE_BIT_CNT (4),
        .DIM_W        (11),
        .ADDR_W       (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_cols    (cfg_cols),
        .cfg_rows    (cfg_rows),
        .cfg_bayer   (cfg_bayer),
        .cfg_base    (cfg_base),
        .cfg_mode    (cfg_mode),
        .pause       (pause),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .pixel_out   (pixel_out),
        .valid_out   (valid_out),
        .color_out   (color_out),
        .last_col_out(last_col_out),
        .last_pic_out(last_pic_out),
        .mode_out    (mode_out),
        .busy        (busy),
        .done        (done)
    );

    // Frame memory whose content equals the low address byte.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_addr[7:0];
    end

    task automatic launch(input logic [10:0] cols, input logic [10:0] rows,
                          input logic [1:0] bayer, input logic [19:0] base,
                          input logic [3:0] mode);
        @(posedge clk); #1;
        cfg_cols  = cols;
        cfg_rows  = rows;
        cfg_bayer = bayer;
        cfg_base  = base;
        cfg_mode  = mode;
        pause     = 1'b0;
        start     = 1'b1;
    endtask

    task automatic run(input int n, input logic [31:0] pmask, input logic [31:0] smask,
                       input bit scramble);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start = smask[k];
            pause = pmask[k];
            if (scramble && k == 1) begin
                cfg_cols  = 11'd2;
                cfg_rows  = 11'd1;
                cfg_bayer = 2'd3;
                cfg_base  = 20'h00080;
                cfg_mode  = 4'd9;
            end
            @(negedge clk);
            c_rd[k]   = mem_rd_en;
            c_addr[k] = mem_addr;
            c_vld[k]  = valid_out;
            c_pix[k]  = pixel_out;
            c_col[k]  = color_out;
            c_lc[k]   = last_col_out;
            c_lp[k]   = last_pic_out;
            c_done[k] = done;
            c_busy[k] = busy;
            c_mode[k] = mode_out;
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] got;
        rst_n = 1'b0; start = 1'b0; pause = 1'b0;
        cfg_cols = '0; cfg_rows = '0; cfg_bayer = '0; cfg_base = '0; cfg_mode = '0;
        repeat (2) @(negedge clk);
        got = {mem_rd_en, mem_addr, pixel_out, valid_out, color_out,
               last_col_out, last_pic_out, mode_out, busy, done};
        n_checks++;
        if (got !== {1'b0, 20'h0, 8'h0, 1'b0, 2'd3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got %h want %h", got, {1'b0, 20'h0, 8'h0, 1'b0, 2'd3, 4'h0, 4'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_rggb();
        logic [1:0] exp_c [8];
        logic       ev;
        int         p;
        exp_c = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2};
        launch(11'd4, 11'd2, 2'd0, 20'h00000, 4'd5);
        run(14, 32'h0, 32'h0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            ev = (k <= 8);
            n_checks++;
            if (c_rd[k] !== ev || (ev && c_addr[k] !== 20'(k - 1))) begin
                n_fail++;
                $display("FAIL basic_read[%0d] got en=%b addr=%h want en=%b addr=%h",
                         k, c_rd[k], c_addr[k], ev, 20'(k - 1));
            end
            ev = (k >= 3 && k <= 10);
            p  = k - 3;
            n_checks++;
            if (c_vld[k] !== ev) begin
                n_fail++;
                $display("FAIL basic_valid[%0d] got %b want %b", k, c_vld[k], ev);
            end else if (ev) begin
                n_checks++;
                if (c_pix[k] !== 8'(p) || c_col[k] !== exp_c[p] ||
                    c_lc[k] !== (p == 3 || p == 7) || c_lp[k] !== (p == 7)) begin
                    n_fail++;
                    $display("FAIL basic_pixel[%0d] got pix=%h col=%0d lc=%b lp=%b want pix=%h col=%0d lc=%b lp=%b",
                             p, c_pix[k], c_col[k], c_lc[k], c_lp[k], 8'(p), exp_c[p],
                             (p == 3 || p == 7), (p == 7));
                end
            end else begin
                n_checks++;
                if (c_col[k] !== 2'd3 || c_lc[k] !== 1'b0 || c_lp[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_idle_tags[%0d] got col=%0d lc=%b lp=%b want col=3 lc=0 lp=0",
                             k, c_col[k], c_lc[k], c_lp[k]);
                end
            end
            n_checks++;
            if (c_done[k] !== (k == 11) || c_busy[k] !== (k <= 10) || c_mode[k] !== 4'd5) begin
                n_fail++;
                $display("FAIL basic_ctrl[%0d] got done=%b busy=%b mode=%0d want done=%b busy=%b mode=5",
                         k, c_done[k], c_busy[k], c_mode[k], (k == 11), (k <= 10));
            end
        end
    endtask

    task automatic test_pause_bggr();
        logic [1:0] exp_c [8];
        int nv, first, last, ndone, done_at;
        exp_c = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0};
        nv = 0; first = -1; last = -1; ndone = 0; done_at = -1;
        launch(11'd4, 11'd2, 2'd3, 20'h00000, 4'd2);
        run(16, 32'h0000_000C, 32'h0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            if (c_done[k] === 1'b1) begin ndone++; done_at = k; end
            if (c_vld[k] === 1'b1) begin
                if (first < 0) first = k;
                last = k;
                n_checks++;
                if (nv >= 8) begin
                    n_fail++;
                    $display("FAIL pause_extra_valid got pixel at cycle %0d want none", k);
                end else if (c_pix[k] !== 8'(nv) || c_col[k] !== exp_c[nv] ||
                             c_lc[k] !== (nv == 3 || nv == 7) || c_lp[k] !== (nv == 7)) begin
                    n_fail++;
                    $display("FAIL pause_pixel[%0d] got pix=%h col=%0d lc=%b lp=%b want pix=%h col=%0d",
                             nv, c_pix[k], c_col[k], c_lc[k], c_lp[k], 8'(nv), exp_c[nv]);
                end
                nv++;
            end
        end
        n_checks++;
        if (c_rd[1] !== 1'b1 || c_rd[2] !== 1'b0 || c_rd[3] !== 1'b0 || c_rd[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_reads got %b%b%b%b want 1001", c_rd[1], c_rd[2], c_rd[3], c_rd[4]);
        end
        n_checks++;
        if (nv !== 8 || first !== 3 || last !== 12 || (last - first + 1 - nv) !== 2) begin
            n_fail++;
            $display("FAIL pause_valid_shape got count=%0d first=%0d last=%0d want count=8 first=3 last=12",
                     nv, first, last);
        end
        n_checks++;
        if (ndone !== 1 || done_at !== 13) begin
            n_fail++;
            $display("FAIL pause_done got count=%0d at=%0d want count=1 at=13", ndone, done_at);
        end
    endtask

    task automatic test_zero_dim();
        launch(11'd0, 11'd2, 2'd0, 20'h00040, 4'd7);
        run(6, 32'h0, 32'h0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            n_checks++;
            if (c_rd[k] !== 1'b0 || c_vld[k] !== 1'b0 || c_busy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_quiet[%0d] got rd=%b vld=%b busy=%b want 0 0 0",
                         k, c_rd[k], c_vld[k], c_busy[k]);
            end
            n_checks++;
            if (c_done[k] !== (k == 2)) begin
                n_fail++;
                $display("FAIL zero_done[%0d] got %b want %b", k, c_done[k], (k == 2));
            end
        end
        n_checks++;
        if (c_mode[6] !== 4'd7) begin
            n_fail++;
            $display("FAIL zero_mode got %0d want 7", c_mode[6]);
        end
    endtask

    task automatic test_addr_wrap();
        logic [19:0] exp_a [4];
        logic [1:0]  exp_c [4];
        int p;
        exp_a = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        exp_c = '{2'd0, 2'd1, 2'd1, 2'd2};
        launch(11'd2, 11'd2, 2'd0, 20'hFFFFE, 4'd1);
        run(10, 32'h0, 32'h0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (c_rd[k] !== 1'b1 || c_addr[k] !== exp_a[k-1]) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d] got en=%b addr=%h want en=1 addr=%h",
                         k, c_rd[k], c_addr[k], exp_a[k-1]);
            end
        end
        for (int k = 3; k <= 6; k++) begin
            p = k - 3;
            n_checks++;
            if (c_vld[k] !== 1'b1 || c_pix[k] !== exp_a[p][7:0] || c_col[k] !== exp_c[p] ||
                c_lc[k] !== (p == 1 || p == 3) || c_lp[k] !== (p == 3)) begin
                n_fail++;
                $display("FAIL wrap_pixel[%0d] got vld=%b pix=%h col=%0d lc=%b lp=%b want pix=%h col=%0d",
                         p, c_vld[k], c_pix[k], c_col[k], c_lc[k], c_lp[k], exp_a[p][7:0], exp_c[p]);
            end
        end
        n_checks++;
        if (c_rd[5] !== 1'b0 || c_vld[7] !== 1'b0 || c_done[7] !== 1'b1 || c_done[6] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end got rd5=%b vld7=%b done6=%b done7=%b want 0 0 0 1",
                     c_rd[5], c_vld[7], c_done[6], c_done[7]);
        end
    endtask

    task automatic test_start_while_busy();
        logic [1:0] exp_c [8];
        int nv, ndone;
        exp_c = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2};
        nv = 0; ndone = 0;
        launch(11'd4, 11'd2, 2'd0, 20'h00010, 4'd5);
        run(14, 32'h0, 32'h0000_0828, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            if (c_done[k] === 1'b1) ndone++;
            if (c_vld[k] === 1'b1) begin
                n_checks++;
                if (nv >= 8 || c_pix[k] !== 8'(16 + nv) || c_col[k] !== exp_c[nv[2:0]]) begin
                    n_fail++;
                    $display("FAIL busy_start_pixel[%0d] got pix=%h col=%0d want pix=%h", nv,
                             c_pix[k], c_col[k], 8'(16 + nv));
                end
                nv++;
            end
            n_checks++;
            if (c_mode[k] !== 4'd5) begin
                n_fail++;
                $display("FAIL busy_start_mode[%0d] got %0d want 5", k, c_mode[k]);
            end
        end
        n_checks++;
        if (nv !== 8 || ndone !== 1 || c_done[11] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_frame got pixels=%0d dones=%0d done11=%b want 8 1 1",
                     nv, ndone, c_done[11]);
        end
        for (int k = 12; k <= 14; k++) begin
            n_checks++;
            if (c_busy[k] !== 1'b0 || c_rd[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL done_cycle_start[%0d] got busy=%b rd=%b want 0 0", k, c_busy[k], c_rd[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [39:0] got;
        int nv;
        launch(11'd4, 11'd4, 2'd0, 20'h00000, 4'd6);
        run(6, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (c_vld[6] !== 1'b1 || c_pix[6] !== 8'h03) begin
            n_fail++;
            $display("FAIL rst_pre_pixel got vld=%b pix=%h want 1 03", c_vld[6], c_pix[6]);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {mem_rd_en, mem_addr, pixel_out, valid_out, color_out,
               last_col_out, last_pic_out, mode_out, busy, done};
        n_checks++;
        if (got !== {1'b0, 20'h0, 8'h0, 1'b0, 2'd3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_frame got %h want %h", got, {1'b0, 20'h0, 8'h0, 1'b0, 2'd3, 4'h0, 4'h0});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || valid_out !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_quiet[%0d] got done=%b vld=%b busy=%b want 0 0 0", k, done, valid_out, busy);
            end
        end
        launch(11'd4, 11'd4, 2'd0, 20'h00000, 4'd6);
        run(22, 32'h0, 32'h0, 1'b0);
        nv = 0;
        for (int k = 1; k <= 22; k++) begin
            if (c_vld[k] === 1'b1) begin
                n_checks++;
                if (k !== nv + 3 || c_pix[k] !== 8'(nv) || c_lc[k] !== (nv % 4 == 3) ||
                    c_lp[k] !== (nv == 15)) begin
                    n_fail++;
                    $display("FAIL rst_refetch[%0d] got cyc=%0d pix=%h lc=%b lp=%b want cyc=%0d pix=%h",
                             nv, k, c_pix[k], c_lc[k], c_lp[k], nv + 3, 8'(nv));
                end
                nv++;
            end
        end
        n_checks++;
        if (nv !== 16 || c_done[19] !== 1'b1 || c_done[18] !== 1'b0 || c_done[20] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_refetch_frame got pixels=%0d done18/19/20=%b%b%b want 16 010",
                     nv, c_done[18], c_done[19], c_done[20]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_rggb();
        test_pause_bggr();
        test_zero_dim();
        test_addr_wrap();
        test_start_while_busy();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
